// File: rtl/cpu_defs.sv
// Shared RV32I pipeline definitions: common words, opcode constants and the
// instruction-fetch state encoding.
package cpu_defs;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] NopInst  = 32'h0000_0013;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: assembles each 32-bit instruction from four little-endian
// byte reads and presents a registered (pc, ins) pair to the decoder.
module if_stage
    import cpu_defs::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_byte,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    input  logic        stall_in,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_ins
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [23:0]  buf_q, buf_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_ins_q, out_ins_d;

    // Gated by reset so no request escapes while the stage is held in reset.
    assign mem_req  = rst_in & rdy_in & ~mem_busy & (state_q == FETCH);
    assign mem_addr = pc_q + {30'b0, cnt_q};

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_ins   = out_ins_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_ins_d   = out_ins_q;
        if (rdy_in) begin
            if (jump_flag) begin
                // Redirect wins; any byte returned this cycle is dropped.
                pc_d        = jump_target & 32'hFFFF_FFFC;
                cnt_d       = 2'd0;
                out_valid_d = 1'b0;
                state_d     = FETCH;
            end else begin
                unique case (state_q)
                    FETCH: begin
                        if (mem_req && mem_ack) begin
                            if (cnt_q == 2'd3) begin
                                out_ins_d   = {mem_byte, buf_q};
                                out_pc_d    = pc_q;
                                out_valid_d = 1'b1;
                                pc_d        = pc_q + 32'd4;
                                cnt_d       = 2'd0;
                                state_d     = HOLD;
                            end else begin
                                buf_d[8*cnt_q +: 8] = mem_byte;
                                cnt_d               = cnt_q + 2'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_valid_q && !stall_in) begin
                            out_valid_d = 1'b0;
                            state_d     = FETCH;
                        end
                    end
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= FETCH;
            pc_q        <= ZeroWord;
            cnt_q       <= 2'd0;
            buf_q       <= 24'd0;
            out_valid_q <= 1'b0;
            out_pc_q    <= ZeroWord;
            out_ins_q   <= ZeroWord;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_ins_q   <= out_ins_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a byte-addressed memory image plus an
// instruction-level model of the fetch stage, checked every cycle.
module tb_if_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in, mem_busy, mem_ack, jump_flag, stall_in;
    logic [31:0] jump_target;
    logic        mem_req, out_valid;
    logic [31:0] mem_addr, out_pc, out_ins;
    logic [7:0]  mem_byte;

    int checks = 0;
    int errors = 0;

    // Model: pc of the instruction being fetched, bytes gathered so far,
    // and the presented instruction.
    logic [31:0] m_pc;
    int          m_got;
    logic        m_valid;
    logic [31:0] m_opc, m_oins;

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'd0) return 8'h13;
        if (a < 32'd4) return 8'h00;
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
    endfunction

    assign mem_byte = byte_at(mem_addr);

    if_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_busy(mem_busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_byte(mem_byte),
        .jump_flag(jump_flag), .jump_target(jump_target), .stall_in(stall_in),
        .out_valid(out_valid), .out_pc(out_pc), .out_ins(out_ins)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_got = 0; m_valid = 1'b0; m_opc = 32'd0; m_oins = 32'd0;
    endtask

    // One clock: drive inputs, check the combinational request, advance the
    // model, then check registered outputs just after the edge.
    task automatic step(input logic rdy, input logic busy, input logic ack,
                        input logic jf, input logic [31:0] jt, input logic stall);
        logic exp_req;
        rdy_in = rdy; mem_busy = busy; mem_ack = ack;
        jump_flag = jf; jump_target = jt; stall_in = stall;
        #1;
        exp_req = rdy && !busy && !m_valid;
        chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
        if (exp_req) chk("mem_addr", mem_addr, m_pc + m_got);
        if (rdy) begin
            if (jf) begin
                m_pc = {jt[31:2], 2'b00}; m_got = 0; m_valid = 1'b0;
            end else if (m_valid) begin
                if (!stall) m_valid = 1'b0;
            end else if (exp_req && ack) begin
                m_got++;
                if (m_got == 4) begin
                    m_opc = m_pc; m_oins = word_at(m_pc); m_valid = 1'b1;
                    m_pc = m_pc + 32'd4; m_got = 0;
                end
            end
        end
        @(posedge clk_in); #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_pc", out_pc, m_opc);
        chk("out_ins", out_ins, m_oins);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; mem_busy = 1'b0; mem_ack = 1'b0;
        jump_flag = 1'b0; jump_target = 32'd0; stall_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_ins", out_ins, 32'd0);
        rst_in = 1'b1;

        // First instruction: 13 00 00 00 at address 0
        repeat (4) step(1, 0, 1, 0, 0, 0);
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_pc", out_pc, 32'h0000_0000);
        chk("first_ins", out_ins, 32'h0000_0013);
        repeat (3) step(1, 0, 1, 0, 0, 1);
        chk("stall_hold_ins", out_ins, 32'h0000_0013);
        step(1, 0, 1, 0, 0, 0);
        chk("after_accept_req", {31'b0, mem_req}, 32'd1);
        chk("after_accept_addr", mem_addr, 32'h0000_0004);

        // Memory busy between byte 1 and byte 2
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("busy_ins", out_ins, word_at(32'd4));
        step(1, 0, 0, 0, 0, 0);

        // Redirect during byte 2 ack
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 1, 32'h0000_1006, 0);
        chk("jump_addr", mem_addr, 32'h0000_1004);
        chk("jump_valid", {31'b0, out_valid}, 32'd0);

        // PC wrap
        step(1, 0, 0, 1, 32'hFFFF_FFFC, 0);
        repeat (4) step(1, 0, 1, 0, 0, 0);
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        chk("wrap_addr", mem_addr, 32'h0000_0000);

        // Async reset mid-fetch at 0x40
        step(1, 0, 0, 1, 32'h0000_0040, 0);
        repeat (4) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        chk("arst_restart", mem_addr, 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, tgt,
                 $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
